// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one result bit per clock, LSB first, through a nand-built full adder.
// Optional signed-overflow output is compiled in when SERIAL_OVF_EN is defined.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             fa_s;
  logic             fa_co;
  logic             last;

  // Full adder from two-input nands only; returns {carry, sum}.
  function automatic logic [1:0] nand_fa(input logic x, input logic y, input logic ci);
    logic n1, n2, n3, hx, n4, n5, n6;
    n1 = ~(x & y);
    n2 = ~(x & n1);
    n3 = ~(y & n1);
    hx = ~(n2 & n3);
    n4 = ~(hx & ci);
    n5 = ~(hx & n4);
    n6 = ~(ci & n4);
    return {~(n1 & n4), ~(n5 & n6)};
  endfunction

  always_comb begin
    {fa_co, fa_s} = nand_fa(a_r[cnt], b_r[cnt] ^ op_r, cy);
    acc_nx        = acc;
    acc_nx[cnt]   = fa_s;
    last          = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cy     <= 1'b0;
      op_r   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            cy    <= op;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_nx;
          cy  <= fa_co;
          cnt <= cnt + CW'(1);
          if (last) begin
            // cy here is still the carry into the MSB, needed for overflow.
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_nx;
            cout   <= fa_co;
`ifdef SERIAL_OVF_EN
            ovf    <= cy ^ fa_co;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl (WIDTH=8); define SERIAL_OVF_EN to also check ovf.
module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] result;
`ifdef SERIAL_OVF_EN
  logic         ovf;
`endif

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout)
`ifdef SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    exp_t e;
    int   ux, uy, sx, sy, u, s;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    u  = sub ? ux - uy : ux + uy;
    s  = sub ? sx - sy : sx + sy;
    e.r = W'(u);
    e.c = sub ? (ux >= uy) : (u > 255);
    e.v = (s > 127) || (s < -128);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected completion.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", 32'(result), 32'(e.r));
        check("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_OVF_EN
        check("ovf", 32'(ovf), 32'(e.v));
`endif
      end
    end
  end

  // Issues one op at the current negedge and waits for done; optional stray start at RUN cycle inj.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                        input int inj, output int lat, output int bcyc);
    a = x; b = y; op = sub; start = 1'b1;
    q.push_back(model(x, y, sub));
    lat = 0; bcyc = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      start = (lat == inj);
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      if (busy === 1'b1) bcyc++;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    if (lat >= 30) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done after %0d cycles expected done", lat);
    end
  endtask

  int lat, bc;
  logic seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_cout", 32'(cout), 0);
`ifdef SERIAL_OVF_EN
    check("rst_ovf", 32'(ovf), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h25, 8'h17, 1'b0, -1, lat, bc);
    check("latency", 32'(lat), 9);
    check("busy_cycles", 32'(bc), 8);
    check("add_lit", 32'(result), 32'h3C);
    @(negedge clk);
    check("idle_done_low", 32'(done), 0);
    check("held_result", 32'(result), 32'h3C);

    run_op(8'hFF, 8'h01, 1'b0, -1, lat, bc);
    check("wrap_lit", 32'(result), 32'h00);
    check("wrap_cout", 32'(cout), 1);
    @(negedge clk);
    run_op(8'h10, 8'h01, 1'b1, -1, lat, bc);
    check("sub_lit", 32'(result), 32'h0F);
    @(negedge clk);
    run_op(8'h00, 8'h01, 1'b1, -1, lat, bc);
    check("borrow_lit", 32'(result), 32'hFF);
    check("borrow_cout", 32'(cout), 0);
    @(negedge clk);
    run_op(8'h7F, 8'h01, 1'b0, -1, lat, bc);
    @(negedge clk);
    run_op(8'h80, 8'h01, 1'b1, -1, lat, bc);
    @(negedge clk);

    // Stray start in RUN is ignored; start during DONE chains directly.
    run_op(8'h11, 8'h22, 1'b0, 3, lat, bc);
    check("ignore_lit", 32'(result), 32'h33);
    check("ignore_latency", 32'(lat), 9);
    run_op(8'h40, 8'h05, 1'b1, -1, lat, bc);
    check("b2b_latency", 32'(lat), 9);
    check("b2b_busy", 32'(bc), 8);

    // Reset at RUN cycle 4 aborts without a done pulse.
    @(negedge clk);
    a = 8'h25; b = 8'h17; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("run4_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_result", 32'(result), 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort_quiet", 32'(seen), 0);

    // Reset wins over start on the same edge.
    a = 8'h01; b = 8'h02; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_prio_busy", 32'(busy), 0);
    @(negedge clk);
    check("rst_prio_idle", 32'(busy), 0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 5 : -1, lat, bc);
      check("rand_latency", 32'(lat), 9);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
